merge_score_accumulator: RTL and testbench

// - Converts tile-merge events (log2 exponent per lane) into 2^e point values and adds them to a running game score.
// - Tracks the best score and raises saturation/bad-exponent flags.
// - Placed between the board-merge engine (up to LANES merges per move beat) and the score display/BCD path.
// - Handles several lanes per beat, has a valid/ready input and a 2-stage pipeline, and supports new-game clear.

---
 rtl/merge_score_accumulator_pkg.sv | 17 +
 rtl/merge_score_accumulator_tile_exp_decoder.sv | 21 ++
 rtl/merge_score_accumulator.sv | 108 ++++++++++
 tb/tb_merge_score_accumulator.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/merge_score_accumulator_pkg.sv
// Shared definitions for the merge score accumulator: exponent encodings,
// FSM state type and the exponent-to-points decode function.
package merge_score_accumulator_pkg;
  localparam int EXP_EMPTY   = 0;
  localparam int MAX_EXP_DEF = 14;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

  // 2^e for a legal tile exponent; empty and out-of-range exponents are worth nothing.
  function automatic logic [31:0] exp2val(input logic [31:0] e, input int max_exp);
    if (e == 32'(EXP_EMPTY) || e > 32'(max_exp)) return '0;
    return 32'd1 << e;
  endfunction
endpackage

// File: rtl/merge_score_accumulator_tile_exp_decoder.sv
// One merge lane: turns a tile exponent into its point value and flags
// masked-in exponents that no legal tile can carry.
module tile_exp_decoder
  import merge_score_accumulator_pkg::*;
#(
  parameter int EXP_W   = 4,
  parameter int MAX_EXP = MAX_EXP_DEF
) (
  input  logic [EXP_W-1:0] exp,
  input  logic             mask,
  output logic [MAX_EXP:0] value,
  output logic             bad
);
  logic [31:0] dec;
  logic        unused_hi;

  assign dec       = exp2val(32'(exp), MAX_EXP);
  assign value     = mask ? dec[MAX_EXP:0] : '0;
  assign bad       = mask & (32'(exp) > 32'(MAX_EXP));
  assign unused_hi = ^dec[31:MAX_EXP+1];
endmodule

// File: rtl/merge_score_accumulator.sv
// Sums per-lane merge points each beat and folds them into a saturating game
// score two cycles later; keeps the best score and a RUN/FLUSH new-game FSM.
module merge_score_accumulator
  import merge_score_accumulator_pkg::*;
#(
  parameter int LANES   = 4,
  parameter int EXP_W   = 4,
  parameter int MAX_EXP = MAX_EXP_DEF,
  parameter int SCORE_W = 20
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [LANES*EXP_W-1:0]   merge_exp,
  input  logic [LANES-1:0]         merge_mask,
  output logic [SCORE_W-1:0]       score,
  output logic [SCORE_W-1:0]       best,
  output logic                     score_upd,
  output logic                     saturated,
  output logic                     bad_exp
);
  localparam int VAL_W  = MAX_EXP + 1;
  localparam int SUM_W  = VAL_W + $clog2(LANES);
  // Wide enough that neither the score nor a whole beat sum can wrap.
  localparam int ACC_W  = ((SUM_W > SCORE_W) ? SUM_W : SCORE_W) + 1;
  localparam int STAGES = 2;
  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

  logic [LANES-1:0][VAL_W-1:0] lane_val;
  logic [LANES-1:0]            lane_bad;
  logic [SUM_W-1:0]            sum, s1_sum;
  logic                        s1_bad;
  logic [STAGES:1]             vld_pipe;
  logic [ACC_W-1:0]            acc;
  logic                        sat_hit;
  logic [SCORE_W-1:0]          score_nxt;
  logic                        accept;
  state_t                      state, state_nxt;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    tile_exp_decoder #(.EXP_W(EXP_W), .MAX_EXP(MAX_EXP)) u_dec (
      .exp   (merge_exp[i*EXP_W +: EXP_W]),
      .mask  (merge_mask[i]),
      .value (lane_val[i]),
      .bad   (lane_bad[i])
    );
  end

  always_comb begin
    sum = '0;
    for (int i = 0; i < LANES; i++) sum = sum + SUM_W'(lane_val[i]);
  end

  always_ff @(posedge clk) begin
    if (!rst) state <= ST_RUN;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    case (state)
      ST_RUN: begin
        in_ready = ~clear;
        if (clear) state_nxt = ST_FLUSH;
      end
      ST_FLUSH: if (!clear) state_nxt = ST_RUN;
      default:  state_nxt = ST_RUN;
    endcase
  end

  assign accept    = in_valid & in_ready;
  assign acc       = ACC_W'(score) + ACC_W'(s1_sum);
  assign sat_hit   = acc > ACC_W'(SCORE_MAX);
  assign score_nxt = sat_hit ? SCORE_MAX : acc[SCORE_W-1:0];
  assign score_upd = vld_pipe[STAGES];

  always_ff @(posedge clk) begin
    if (!rst) begin
      vld_pipe  <= '0;
      s1_sum    <= '0;
      s1_bad    <= 1'b0;
      score     <= '0;
      best      <= '0;
      saturated <= 1'b0;
      bad_exp   <= 1'b0;
    end else begin
      // accept is already low under clear, which drops the stage-1 slot.
      vld_pipe[1] <= accept;
      vld_pipe[2] <= vld_pipe[1] & ~clear;
      s1_sum      <= sum;
      s1_bad      <= |lane_bad;
      if (clear) begin
        score     <= '0;
        saturated <= 1'b0;
        bad_exp   <= 1'b0;
        if (score > best) best <= score;
      end else if (vld_pipe[1]) begin
        score     <= score_nxt;
        saturated <= saturated | sat_hit;
        bad_exp   <= bad_exp | s1_bad;
        if (score_nxt > best) best <= score_nxt;
      end
    end
  end
endmodule

// File: tb/tb_merge_score_accumulator.sv
// Scoreboard bench: beats push expected score/best/flags; per-instance monitors
// pop and compare on every score_upd pulse.
module tb_merge_score_accumulator;
  localparam int LANES = 4;
  localparam int EXP_W = 4;
  localparam int SW    = 20;
  localparam int SWS   = 12;

  logic clk = 1'b0, rst = 1'b0, clear = 1'b0, sat_clear = 1'b0;
  logic in_valid = 1'b0, sat_valid = 1'b0;
  logic [LANES*EXP_W-1:0] merge_exp = '0;
  logic [LANES-1:0]       merge_mask = '0;

  logic           in_ready, score_upd, saturated, bad_exp;
  logic [SW-1:0]  score, best;
  logic           s_ready, s_upd, s_sat, s_bad;
  logic [SWS-1:0] s_score, s_best;

  typedef struct packed {
    logic [SW-1:0] score;
    logic [SW-1:0] best;
    logic          sat;
    logic          bad;
  } exp_t;

  exp_t qm[$];
  exp_t qs[$];
  int tests = 0, fails = 0;

  merge_score_accumulator #(.LANES(LANES), .EXP_W(EXP_W), .MAX_EXP(14), .SCORE_W(SW)) dut (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .merge_exp(merge_exp), .merge_mask(merge_mask), .score(score), .best(best),
    .score_upd(score_upd), .saturated(saturated), .bad_exp(bad_exp)
  );

  merge_score_accumulator #(.LANES(LANES), .EXP_W(EXP_W), .MAX_EXP(14), .SCORE_W(SWS)) dut_sat (
    .clk(clk), .rst(rst), .clear(sat_clear), .in_valid(sat_valid), .in_ready(s_ready),
    .merge_exp(merge_exp), .merge_mask(merge_mask), .score(s_score), .best(s_best),
    .score_upd(s_upd), .saturated(s_sat), .bad_exp(s_bad)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  function automatic exp_t mk(input int sc, input int bs, input bit st, input bit bd);
    exp_t e;
    e.score = SW'(sc);
    e.best  = SW'(bs);
    e.sat   = st;
    e.bad   = bd;
    return e;
  endfunction

  always @(negedge clk) begin
    if (rst && score_upd) begin
      if (qm.size() == 0) chk("main_unexpected_upd", 32'd1, 32'd0);
      else begin
        exp_t e;
        e = qm.pop_front();
        chk("main_score", 32'(score), 32'(e.score));
        chk("main_best", 32'(best), 32'(e.best));
        chk("main_saturated", 32'(saturated), 32'(e.sat));
        chk("main_bad_exp", 32'(bad_exp), 32'(e.bad));
      end
    end
  end

  always @(negedge clk) begin
    if (rst && s_upd) begin
      if (qs.size() == 0) chk("sat_unexpected_upd", 32'd1, 32'd0);
      else begin
        exp_t e;
        e = qs.pop_front();
        chk("sat_score", 32'(s_score), 32'(e.score));
        chk("sat_best", 32'(s_best), 32'(e.best));
        chk("sat_saturated", 32'(s_sat), 32'(e.sat));
        chk("sat_bad_exp", 32'(s_bad), 32'(e.bad));
      end
    end
  end

  // Presents one beat for a single cycle once the target instance is ready.
  task automatic beat(input bit to_sat, input logic [15:0] ex, input logic [3:0] mk_in, input exp_t e);
    int n = 0;
    while (!(to_sat ? s_ready : in_ready) && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("ready_wait", 32'(n < 20), 32'd1);
    merge_exp  = ex;
    merge_mask = mk_in;
    if (to_sat) begin sat_valid = 1'b1; qs.push_back(e); end
    else begin in_valid = 1'b1; qm.push_back(e); end
    @(posedge clk); #1;
    in_valid   = 1'b0;
    sat_valid  = 1'b0;
    merge_exp  = '0;
    merge_mask = '0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
  endtask

  task automatic drain();
    repeat (4) begin @(posedge clk); #1; end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with junk on every input
    repeat (3) begin
      merge_exp  = 16'($urandom);
      merge_mask = 4'($urandom);
      in_valid   = 1'($urandom);
      sat_valid  = 1'($urandom);
      clear      = 1'($urandom);
      @(posedge clk); #1;
    end
    in_valid = 1'b0; sat_valid = 1'b0; clear = 1'b0;
    merge_exp = '0; merge_mask = '0;
    rst = 1'b1;
    @(negedge clk);
    chk("rst_score", 32'(score), 32'd0);
    chk("rst_best", 32'(best), 32'd0);
    chk("rst_upd", 32'(score_upd), 32'd0);
    chk("rst_saturated", 32'(saturated), 32'd0);
    chk("rst_bad_exp", 32'(bad_exp), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_sat_score", 32'(s_score), 32'd0);
    @(posedge clk); #1;

    // Saturation on the 12-bit instance
    beat(1'b1, 16'h000B, 4'b0001, mk(2048, 2048, 1'b0, 1'b0));
    beat(1'b1, 16'h000B, 4'b0001, mk(4095, 4095, 1'b1, 1'b0));
    beat(1'b1, 16'h000B, 4'b0001, mk(4095, 4095, 1'b1, 1'b0));
    drain();

    // Single beat, latency and one-cycle pulse
    beat(1'b0, {4'd0, 4'd3, 4'd2, 4'd1}, 4'b1111, mk(14, 14, 1'b0, 1'b0));
    @(negedge clk);
    chk("single_t1_score", 32'(score), 32'd0);
    chk("single_t1_upd", 32'(score_upd), 32'd0);
    @(negedge clk);
    chk("single_t2_score", 32'(score), 32'd14);
    chk("single_t2_upd", 32'(score_upd), 32'd1);
    @(negedge clk);
    chk("single_t3_upd", 32'(score_upd), 32'd0);
    drain();

    // New game with empty pipeline, then masked and back-to-back beats
    pulse_clear();
    chk("flush_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    chk("clear_score", 32'(score), 32'd0);
    chk("clear_keeps_best", 32'(best), 32'd14);
    beat(1'b0, 16'hBBBB, 4'b0011, mk(4096, 4096, 1'b0, 1'b0));
    beat(1'b0, 16'h2222, 4'b1111, mk(4112, 4112, 1'b0, 1'b0));
    @(negedge clk);
    chk("b2b_t2_score", 32'(score), 32'd4096);
    @(negedge clk);
    chk("b2b_t3_score", 32'(score), 32'd4112);
    drain();

    // Bad exponent: masked-out is harmless, masked-in is sticky
    beat(1'b0, 16'h001F, 4'b0010, mk(4114, 4114, 1'b0, 1'b0));
    beat(1'b0, 16'h001F, 4'b0011, mk(4116, 4116, 1'b0, 1'b1));
    beat(1'b0, 16'h0000, 4'b1111, mk(4116, 4116, 1'b0, 1'b1));
    drain();

    // Reset mid-game, build score 100, then clear with a beat in flight
    rst = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(negedge clk);
    chk("rst2_best", 32'(best), 32'd0);
    chk("rst2_bad_exp", 32'(bad_exp), 32'd0);
    beat(1'b0, 16'h6520, 4'b1111, mk(100, 100, 1'b0, 1'b0));
    drain();
    beat(1'b0, 16'h0003, 4'b0001, mk(0, 0, 1'b0, 1'b0));
    void'(qm.pop_back());
    clear = 1'b1;
    #1;
    chk("cmf_t1_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    clear = 1'b0;
    @(negedge clk);
    chk("cmf_t2_score", 32'(score), 32'd0);
    chk("cmf_t2_upd", 32'(score_upd), 32'd0);
    chk("cmf_t2_in_ready", 32'(in_ready), 32'd0);
    chk("cmf_t2_best", 32'(best), 32'd100);
    @(posedge clk); #1;
    chk("cmf_t3_in_ready", 32'(in_ready), 32'd1);
    drain();
    chk("cmf_best_final", 32'(best), 32'd100);
    chk("cmf_score_final", 32'(score), 32'd0);

    chk("main_queue_empty", 32'(qm.size()), 32'd0);
    chk("sat_queue_empty", 32'(qs.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
